// File: rtl/parking_emu_pkg.sv
// Shared types and constants for the parking sensor emulator.
// Holds the sequence state encoding, the request direction, the (a,b)
// pattern driven in each phase per direction, and a decode helper.
package parking_emu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH1  = 3'd1,
    PH2  = 3'd2,
    PH3  = 3'd3,
    GAP  = 3'd4
  } state_t;

  typedef enum logic {
    DIR_ENTER = 1'b0,
    DIR_EXIT  = 1'b1
  } dir_t;

  // (a,b) patterns; bit 1 = a, bit 0 = b
  localparam logic [1:0] AB_CLEAR  = 2'b00;
  localparam logic [1:0] ENTER_PH1 = 2'b10;
  localparam logic [1:0] ENTER_PH2 = 2'b11;
  localparam logic [1:0] ENTER_PH3 = 2'b01;
  localparam logic [1:0] EXIT_PH1  = 2'b01;
  localparam logic [1:0] EXIT_PH2  = 2'b11;
  localparam logic [1:0] EXIT_PH3  = 2'b10;

  // Sensor pattern for a given state and direction
  function automatic logic [1:0] phase_ab(input state_t s, input dir_t d);
    logic [1:0] ab;
    ab = AB_CLEAR;
    case (s)
      PH1:     ab = (d == DIR_ENTER) ? ENTER_PH1 : EXIT_PH1;
      PH2:     ab = (d == DIR_ENTER) ? ENTER_PH2 : EXIT_PH2;
      PH3:     ab = (d == DIR_ENTER) ? ENTER_PH3 : EXIT_PH3;
      default: ab = AB_CLEAR;
    endcase
    return ab;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase duration timer: counts 0..PHASE_CYCLES-1 and flags the last count.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous active-high reset
//   clear  - restart the count at 0 on the next edge
//   expire - high while the count equals PHASE_CYCLES-1
module phase_timer #(
  parameter int unsigned PHASE_CYCLES = 2_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(PHASE_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PHASE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // Free-running count, restarted by clear
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expire = (cnt_q == LAST);

endmodule

// File: rtl/parking_sensor_emulator.sv
// Parking sensor emulator: plays the photo-sensor (a,b) blocking sequence of
// a car entering or exiting, one valid/ready request at a time.
// Optional feature macro: PARKING_EMU_OCC_EN (occupancy counter, refusal of
// impossible requests, occupancy/rejected ports).
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   req_valid/req_dir - request and direction (0 enter, 1 exit)
//   req_ready         - request can be accepted
//   a, b              - emulated sensor lines (1 = blocked)
//   busy              - sequence in progress
//   done              - one-cycle pulse as a sequence completes
//   occupancy         - net cars generated (PARKING_EMU_OCC_EN only)
//   rejected          - one-cycle pulse on a refused request (PARKING_EMU_OCC_EN only)
module parking_sensor_emulator
  import parking_emu_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = 2_500_000,
  parameter int unsigned MAX_OCC      = 99,
  parameter int unsigned OCC_W        = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid,
  input  logic req_dir,
  output logic req_ready,
  output logic a,
  output logic b,
  output logic busy,
  output logic done
`ifdef PARKING_EMU_OCC_EN
  ,
  output logic [OCC_W-1:0] occupancy,
  output logic             rejected
`endif
);

  // Elaboration-time parameter sanity check
  if (PHASE_CYCLES < 2 || 64'(MAX_OCC) >= (64'd1 << OCC_W)) begin : g_bad_cfg
    $error("parking_sensor_emulator: illegal PHASE_CYCLES/MAX_OCC/OCC_W");
  end

  state_t     state_q, state_d;
  dir_t       dir_q, dir_d;
  logic [1:0] ab_q, ab_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ready_q, ready_d;
  logic       expire;
  logic       refuse_c;
  logic       reject_d;

  phase_timer #(
    .PHASE_CYCLES(PHASE_CYCLES)
  ) u_phase_timer (
    .clk   (clk),
    .reset (reset),
    .clear ((state_q == IDLE) || expire),
    .expire(expire)
  );

`ifdef PARKING_EMU_OCC_EN
  logic [OCC_W-1:0] occ_q;
  logic             rejected_q;

  // Entering a full lot or exiting an empty one is refused
  assign refuse_c = (dir_t'(req_dir) == DIR_ENTER) ? (occ_q == OCC_W'(MAX_OCC))
                                                   : (occ_q == '0);
`else
  assign refuse_c = 1'b0;
`endif

  // Next-state and registered-output decode
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    done_d   = 1'b0;
    reject_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          dir_d = dir_t'(req_dir);
          if (refuse_c) begin
            reject_d = 1'b1;
          end else begin
            state_d = PH1;
          end
        end
      end
      PH1: if (expire) state_d = PH2;
      PH2: if (expire) state_d = PH3;
      PH3: if (expire) state_d = GAP;
      GAP: begin
        if (expire) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs follow the state being entered so they line up with it
    ab_d    = phase_ab(state_d, dir_d);
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= DIR_ENTER;
      ab_q    <= AB_CLEAR;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      ab_q    <= ab_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

`ifdef PARKING_EMU_OCC_EN
  // Occupancy moves with each completed sequence, visible alongside done
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q      <= '0;
      rejected_q <= 1'b0;
    end else begin
      rejected_q <= reject_d;
      if (done_d) begin
        occ_q <= (dir_q == DIR_ENTER) ? occ_q + OCC_W'(1) : occ_q - OCC_W'(1);
      end
    end
  end

  assign occupancy = occ_q;
  assign rejected  = rejected_q;
`else
  logic unused_reject;
  assign unused_reject = reject_d;
`endif

  assign a    = ab_q[1];
  assign b    = ab_q[0];
  assign busy = busy_q;
  assign done = done_q;
  // Ready is withheld while reset is asserted; the register itself resets to 1
  assign req_ready = ready_q & ~reset;

endmodule

// File: doc/parking_sensor_emulator.md
# parking_sensor_emulator

Stimulus source for the parking-lot occupancy path: drives the two photo-sensor lines (a, b) with the exact blocking sequence a car produces when entering or exiting. One request (enter or exit) is accepted at a time over a valid/ready handshake. Outputs connect to the sensor inputs of the occupancy FSM, either directly or through its input debouncers, so the lot logic can be exercised on-board and in simulation without manual switch toggling.

## Interface
- PHASE_CYCLES, default 2_500_000: clocks each sensor phase is held (25 ms at 100 MHz, longer than the 2^21-cycle debounce window); legal range ≥ 2.
- MAX_OCC, default 99: occupancy ceiling (used only with PARKING_EMU_OCC_EN).
- OCC_W, default 7: occupancy width; must satisfy 2^OCC_W > MAX_OCC.
- clk  input  1  single system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_dir  input  1  0 = enter, 1 = exit; sampled only on handshake.
- req_ready  output  1  block can accept a request.
- a  output  1  sensor a blocked (1) / clear (0).
- b  output  1  sensor b blocked (1) / clear (0).
- busy  output  1  sequence in progress.
- done  output  1  one-cycle pulse when a sequence completes.
- occupancy  output  OCC_W  net cars generated (only with PARKING_EMU_OCC_EN).
- rejected  output  1  one-cycle pulse when a request is refused (only with PARKING_EMU_OCC_EN).

## Operation
- States: IDLE, PH1, PH2, PH3, GAP.
- IDLE: a=b=0, busy=0, req_ready=1. Handshake is req_valid & req_ready on a rising edge; req_dir is latched into dir_q, and the next state is PH1.
- Enter (dir 0) drives (a,b): PH1 = 10, PH2 = 11, PH3 = 01, GAP = 00.
- Exit (dir 1) drives (a,b): PH1 = 01, PH2 = 11, PH3 = 10, GAP = 00.
- Each non-IDLE state lasts exactly PHASE_CYCLES cycles. The phase timer counts 0..PHASE_CYCLES-1 and clears on every state change.
- After GAP the state returns to IDLE and done pulses for that first IDLE cycle.
- busy=1 and req_ready=0 in PH1..GAP. Requests arriving there are held off; req_valid may stay high.
- a, b, busy, done and req_ready are registered, decoded from the state register only, so outputs are glitch-free.
- Reset values: state IDLE, a=0, b=0, busy=0, done=0, req_ready=1 (in the cycle after reset deasserts; 0 while reset is high), timer 0, dir_q 0, occupancy 0, rejected 0.
- Reset mid-sequence: the next cycle is IDLE with all outputs at reset values. No done pulse is produced and occupancy is not updated.

## Timing
- Handshake on edge T: PH1 is visible from cycle T+1 through T+P (P = PHASE_CYCLES). PH2 occupies T+P+1..T+2P, PH3 T+2P+1..T+3P, GAP T+3P+1..T+4P.
- done=1 and req_ready=1 in cycle T+4P+1.
- Back-to-back operation is allowed: a request accepted in the done cycle starts its PH1 in the following cycle, giving a 1-cycle 00 gap plus the full GAP phase before it.
- Request-to-done latency: 4P+1 cycles.

## Configuration
- PARKING_EMU_OCC_EN defined:
  - An occupancy counter increments on done of an enter sequence and decrements on done of an exit sequence.
  - An enter request when occupancy==MAX_OCC, or an exit request when occupancy==0, is consumed by the handshake but generates no waveform. rejected pulses in the next cycle, the state stays IDLE, and req_ready stays 1.
- PARKING_EMU_OCC_EN undefined: the occupancy and rejected ports and the counter are absent, and every accepted request produces a full sequence.

## Structure
- Package parking_emu_pkg holds:
  - state_t enum {IDLE, PH1, PH2, PH3, GAP};
  - dir_t {DIR_ENTER=1'b0, DIR_EXIT=1'b1};
  - the phase output constants per direction as 2-bit localparams.
- Sub-module phase_timer (parameter PHASE_CYCLES; ports clk, reset, clear, expire) has a $clog2(PHASE_CYCLES)-wide counter. expire is high on count PHASE_CYCLES-1.

## Test plan
Benches run with PHASE_CYCLES=4.
- Reset, then one enter request → (a,b) = 10 for 4 cycles, 11 for 4, 01 for 4, 00 for 4; done in cycle 17 after the handshake.
- Exit request → (a,b) = 01, 11, 10, 00, each for 4 cycles; busy=1 for 16 cycles; done is a single-cycle pulse.
- req_valid held high with alternating req_dir → second handshake lands exactly in the done cycle; no request is lost and none is duplicated.
- Assert reset during PH2 → next cycle a=b=0, busy=0, req_ready=1, no done pulse.
- With PARKING_EMU_OCC_EN: exit at occupancy 0 → rejected pulse, a=b=0 throughout, occupancy stays 0.
- With PARKING_EMU_OCC_EN and MAX_OCC=2: three enters → occupancy 2, third request rejected. Then one exit → occupancy 1.
